// File: rtl/flappy_pkg.sv
// Shared sprite geometry, fetch-state encoding and offset arithmetic for the
// bird sprite pipeline.
package flappy_pkg;

  localparam int SPRITE_W = 16;
  localparam int SPRITE_H = 16;
  localparam int H_ACTIVE = 640;
  localparam int V_TOTAL  = 525;

  typedef enum logic [1:0] {IDLE, CHECK, LATCH} sprite_fetch_t;

  // Distance from a sprite origin to a beam position. Positions left of or
  // above the origin wrap to large values, so a single "< span" compare
  // rejects them.
  function automatic logic [10:0] line_offset(input logic [9:0] pos,
                                              input logic [9:0] origin);
    return {1'b0, pos} - {1'b0, origin};
  endfunction

endpackage

// File: rtl/bird_sprite_ctrl_fetch.sv
// Horizontal-blank row fetcher: selects the ROM row for the next line and
// captures it into the line buffer.
module bird_sprite_ctrl_fetch #(
  parameter int SPRITE_W = flappy_pkg::SPRITE_W,
  parameter int SPRITE_H = flappy_pkg::SPRITE_H,
  parameter int SCALE    = 2,
  parameter int V_TOTAL  = flappy_pkg::V_TOTAL,
  parameter int FETCH_H  = 640
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [9:0]          hcount,
  input  logic [9:0]          vcount,
  input  logic [9:0]          y_l,
  output logic [5:0]          rom_addr,
  input  logic [SPRITE_W-1:0] rom_data,
  output logic [SPRITE_W-1:0] line_buf,
  output logic                line_valid
);
  import flappy_pkg::sprite_fetch_t;

  localparam int          SHIFT  = $clog2(SCALE);
  localparam logic [10:0] SPAN_Y = 11'(SPRITE_H * SCALE);

  sprite_fetch_t state;
  logic [5:0]    addr_q;
  logic [9:0]    nv;
  logic [10:0]   dy;
  logic          in_range;
  logic [5:0]    row_addr;

  always_comb begin
    nv       = (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
    dy       = flappy_pkg::line_offset(nv, y_l);
    in_range = dy < SPAN_Y;
    row_addr = 6'(dy >> SHIFT);
  end

  // The address is presented combinationally during CHECK so it is valid in
  // the same cycle and already reflects a y_l latched on the trigger edge;
  // addr_q keeps it steady through LATCH and while idle.
  assign rom_addr = (state == flappy_pkg::CHECK && in_range) ? row_addr : addr_q;

  // NOTE: every register here, line_buf included, is reset so a mid-line
  // reset leaves no stale row that could be drawn before the next fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= flappy_pkg::IDLE;
      addr_q     <= '0;
      line_buf   <= '0;
      line_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      case (state)
        flappy_pkg::IDLE: begin
          if (hcount == 10'(FETCH_H)) state <= flappy_pkg::CHECK;
        end
        flappy_pkg::CHECK: begin
          if (in_range) begin
            addr_q <= row_addr;
            state  <= flappy_pkg::LATCH;
          end else begin
            line_valid <= 1'b0;
            state      <= flappy_pkg::IDLE;
          end
        end
        flappy_pkg::LATCH: begin
          // Lands after the active area, so the buffer never moves under the beam.
          line_buf   <= rom_data;
          line_valid <= 1'b1;
          state      <= flappy_pkg::IDLE;
        end
        default: state <= flappy_pkg::IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bird_sprite_ctrl.sv
// Per-scanline bird sprite controller: frame-latched position, row fetch in
// horizontal blank and a registered per-pixel sprite flag.
module bird_sprite_ctrl #(
  parameter int SPRITE_W = flappy_pkg::SPRITE_W,
  parameter int SPRITE_H = flappy_pkg::SPRITE_H,
  parameter int SCALE    = 2,
  parameter int H_ACTIVE = flappy_pkg::H_ACTIVE,
  parameter int V_TOTAL  = flappy_pkg::V_TOTAL,
  parameter int FETCH_H  = 640
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [9:0]          hcount,
  input  logic [9:0]          vcount,
  input  logic                video_on,
  input  logic                frame_start,
  input  logic [9:0]          bird_x,
  input  logic [9:0]          bird_y,
  output logic [5:0]          rom_addr,
  input  logic [SPRITE_W-1:0] rom_data,
  output logic                pixel_on
);

  localparam int          SHIFT  = $clog2(SCALE);
  localparam int          COL_W  = $clog2(SPRITE_W);
  localparam logic [10:0] SPAN_X = 11'(SPRITE_W * SCALE);

  logic [9:0]          x_l;
  logic [9:0]          y_l;
  logic [SPRITE_W-1:0] line_buf;
  logic                line_valid;
  logic [10:0]         dx;
  logic [COL_W-1:0]    col;
  logic                hit;

  // Position is sampled once per frame so a mid-frame move cannot tear the sprite.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_l <= '0;
      y_l <= '0;
    end else if (frame_start) begin
      x_l <= bird_x;
      y_l <= bird_y;
    end
  end

  bird_sprite_ctrl_fetch #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H),
    .SCALE    (SCALE),
    .V_TOTAL  (V_TOTAL),
    .FETCH_H  (FETCH_H)
  ) u_fetch (
    .clk        (clk),
    .rst_n      (rst_n),
    .hcount     (hcount),
    .vcount     (vcount),
    .y_l        (y_l),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .line_buf   (line_buf),
    .line_valid (line_valid)
  );

  // Bit SPRITE_W-1 of the row is the leftmost column; the active-width
  // compare is a second guard against wrapping past the right edge.
  always_comb begin
    dx  = flappy_pkg::line_offset(hcount, x_l);
    col = COL_W'(SPRITE_W - 1) - COL_W'(dx >> SHIFT);
    hit = line_valid && video_on && (hcount < 10'(H_ACTIVE)) &&
          (dx < SPAN_X) && line_buf[col];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pixel_on <= 1'b0;
    else        pixel_on <= hit;
  end

endmodule
